// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
// Holds the scan state encoding, blank patterns and the active-low hex font.
package seg_scan_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK0,
        S_SHOW0,
        S_BLANK1,
        S_SHOW1
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] AN_OFF   = 4'hF;
    localparam logic [3:0] AN_SHOW0 = 4'b1110;
    localparam logic [3:0] AN_SHOW1 = 4'b1101;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low, indexed by nibble value.
    localparam logic [6:0] HEX7SEG_ROM [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/Multiplexer.sv
// 2:1 nibble multiplexer feeding the scanner; Selector=0 picks In0.
// Latency: combinational; no backpressure.
module Multiplexer (
    input  logic [3:0] In0,
    input  logic [3:0] In1,
    input  logic       Selector,
    output logic [3:0] DataOut
);

    assign DataOut = Selector ? In1 : In0;

endmodule

// File: rtl/hex7seg_decoder.sv
// Nibble to active-low seven-segment pattern lookup.
// Latency: combinational; no backpressure.
module hex7seg_decoder
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = HEX7SEG_ROM[digit];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes two hex digits onto Basys3 anodes 0/1 with a blank guard before each digit.
// Latency: all outputs registered, one digit per BlankCycles+ShowCycles; no backpressure.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int ShowCycles  = 100000,
    parameter int BlankCycles = 16
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Enable,
    input  logic [3:0] DataIn,
    output logic       Selector,
    output logic [6:0] Seg,
    output logic [3:0] An,
    output logic       Dp
);

    localparam int MaxCycles = (ShowCycles > BlankCycles) ? ShowCycles : BlankCycles;
    localparam int CntW      = $clog2(MaxCycles);
    localparam logic [CntW-1:0] BlankLast = CntW'(BlankCycles - 1);
    localparam logic [CntW-1:0] ShowLast  = CntW'(ShowCycles - 1);

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [3:0]      digit_reg;
    logic            capture;
    logic [3:0]      dec_in;
    logic [6:0]      dec_seg;

    // On the capture cycle decode the live mux output so Seg is valid on the first SHOW cycle.
    assign capture = ((state == S_BLANK0) || (state == S_BLANK1)) && (cnt == BlankLast);
    assign dec_in  = capture ? DataIn : digit_reg;
    assign Dp      = 1'b1;

    hex7seg_decoder u_dec (
        .digit (dec_in),
        .seg   (dec_seg)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            digit_reg <= 4'h0;
            Selector  <= 1'b0;
            An        <= AN_OFF;
            Seg       <= SEG_OFF;
        end else if (!Enable) begin
            state    <= S_IDLE;
            cnt      <= '0;
            Selector <= 1'b0;
            An       <= AN_OFF;
            Seg      <= SEG_OFF;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_BLANK0;
                    cnt      <= '0;
                    Selector <= 1'b0;
                    An       <= AN_OFF;
                end
                S_BLANK0, S_BLANK1: begin
                    if (capture) begin
                        digit_reg <= DataIn;
                        Seg       <= dec_seg;
                        An        <= (state == S_BLANK0) ? AN_SHOW0 : AN_SHOW1;
                        state     <= (state == S_BLANK0) ? S_SHOW0 : S_SHOW1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                S_SHOW0, S_SHOW1: begin
                    Seg <= dec_seg;
                    if (cnt == ShowLast) begin
                        Selector <= (state == S_SHOW0);
                        An       <= AN_OFF;
                        state    <= (state == S_SHOW0) ? S_BLANK1 : S_BLANK0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with ShowCycles=8, BlankCycles=2 and the real Multiplexer.
module tb_seg_scan_driver;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       Enable = 1'b0;
    logic [3:0] In0 = 4'h0;
    logic [3:0] In1 = 4'h0;
    logic [3:0] DataIn;
    logic       Selector;
    logic [6:0] Seg;
    logic [3:0] An;
    logic       Dp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] in0;
        logic [3:0] in1;
        logic [6:0] seg0;
        logic [6:0] seg1;
    } vec_t;

    vec_t       vecs [8];
    logic [6:0] seg_ref [16];

    always #5 Clock = ~Clock;

    Multiplexer u_mux (
        .In0      (In0),
        .In1      (In1),
        .Selector (Selector),
        .DataOut  (DataIn)
    );

    seg_scan_driver #(
        .ShowCycles  (8),
        .BlankCycles (2)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Enable   (Enable),
        .DataIn   (DataIn),
        .Selector (Selector),
        .Seg      (Seg),
        .An       (An),
        .Dp       (Dp)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance until a digit becomes lit straight out of a blank gap.
    task automatic wait_show(input logic [3:0] an_target);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            prev = An;
            @(negedge Clock);
            if (prev == 4'hF && An == an_target) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_show: An=%b never reached %b", An, an_target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'h3, 4'hA, 7'b0110000, 7'b0001000};
        vecs[1] = '{4'h0, 4'hF, 7'b1000000, 7'b0001110};
        vecs[2] = '{4'h8, 4'h1, 7'b0000000, 7'b1111001};
        vecs[3] = '{4'hB, 4'hC, 7'b0000011, 7'b1000110};
        vecs[4] = '{4'hD, 4'hE, 7'b0100001, 7'b0000110};
        vecs[5] = '{4'h2, 4'h7, 7'b0100100, 7'b1111000};
        vecs[6] = '{4'h6, 4'h9, 7'b0000010, 7'b0010000};
        vecs[7] = '{4'h4, 4'h5, 7'b0011001, 7'b0010010};
        seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // Reset values while held in reset with Enable already high
        In0    = 4'h0;
        In1    = 4'hA;
        Enable = 1'b1;
        nReset = 1'b0;
        #12;
        chk("rst_an", An, 4'hF);
        chk("rst_seg", Seg, 7'h7F);
        chk("rst_sel", Selector, 1'b0);
        chk("rst_dp", Dp, 1'b1);

        // Cycle-exact scan after release: 2 blank, 8 show0, 2 blank, 8 show1
        @(negedge Clock);
        nReset = 1'b1;
        for (int i = 1; i <= 42; i++) begin
            int p;
            logic [3:0] ea;
            logic       es;
            @(negedge Clock);
            p = (i - 1) % 20;
            if (p < 2) begin
                ea = 4'hF; es = 1'b0;
            end else if (p < 10) begin
                ea = 4'b1110; es = 1'b0;
                chk("scan_seg0", Seg, 7'b1000000);
            end else if (p < 12) begin
                ea = 4'hF; es = 1'b1;
            end else begin
                ea = 4'b1101; es = 1'b1;
                chk("scan_seg1", Seg, 7'b0001000);
            end
            chk("scan_an", An, ea);
            chk("scan_sel", Selector, es);
        end

        // Table of hand-decoded digit pairs
        for (int v = 0; v < 8; v++) begin
            @(negedge Clock);
            In0 = vecs[v].in0;
            In1 = vecs[v].in1;
            wait_show(4'b1110);
            chk("vec_seg0", Seg, vecs[v].seg0);
            wait_show(4'b1101);
            chk("vec_seg1", Seg, vecs[v].seg1);
        end

        // Full 16x16 sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge Clock);
                In0 = a[3:0];
                In1 = b[3:0];
                wait_show(4'b1110);
                chk("sweep_seg0", Seg, seg_ref[a]);
                wait_show(4'b1101);
                chk("sweep_seg1", Seg, seg_ref[b]);
            end
        end

        // DataIn change mid-SHOW1 must wait for the next capture
        @(negedge Clock);
        In0 = 4'h0;
        In1 = 4'h5;
        wait_show(4'b1101);
        chk("hold_seg_before", Seg, 7'b0010010);
        repeat (3) @(negedge Clock);
        In1 = 4'h9;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            chk("hold_seg", Seg, 7'b0010010);
            chk("hold_an", An, 4'b1101);
        end
        wait_show(4'b1101);
        chk("hold_seg_after", Seg, 7'b0010000);

        // Enable dropped mid-SHOW0 blanks on the next edge, restart has a full blank
        wait_show(4'b1110);
        repeat (3) @(negedge Clock);
        Enable = 1'b0;
        @(negedge Clock);
        chk("en_an", An, 4'hF);
        chk("en_seg", Seg, 7'h7F);
        chk("en_sel", Selector, 1'b0);
        repeat (3) @(negedge Clock);
        chk("en_idle_an", An, 4'hF);
        Enable = 1'b1;
        @(negedge Clock);
        chk("en_blank_a", An, 4'hF);
        @(negedge Clock);
        chk("en_blank_b", An, 4'hF);
        @(negedge Clock);
        chk("en_show_an", An, 4'b1110);
        chk("en_show_seg", Seg, 7'b1000000);

        // Short asynchronous reset pulse mid-SHOW1 with no clock edge inside it
        wait_show(4'b1101);
        repeat (2) @(negedge Clock);
        #1 nReset = 1'b0;
        #1;
        chk("arst_an", An, 4'hF);
        chk("arst_seg", Seg, 7'h7F);
        chk("arst_sel", Selector, 1'b0);
        chk("arst_dp", Dp, 1'b1);
        #1 nReset = 1'b1;
        @(negedge Clock);
        chk("arst_blank_a", An, 4'hF);
        chk("arst_blank_sel", Selector, 1'b0);
        @(negedge Clock);
        chk("arst_blank_b", An, 4'hF);
        @(negedge Clock);
        chk("arst_show_an", An, 4'b1110);
        chk("arst_show_seg", Seg, 7'b1000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
